// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: merges the in-order writeback stream with
// buffered MDU results, with a starvation counter that forces the MDU head through.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipe_valid,
  input  logic                     pipe_we,
  input  logic [4:0]               pipe_rd,
  input  logic [63:0]              pipe_data,
  output logic                     pipe_stall,
  input  logic                     mdu_valid,
  input  logic [4:0]               mdu_rd,
  input  logic [63:0]              mdu_data,
  output logic                     mdu_ready,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [63:0]              rf_wdata,
  input  logic [4:0]               query_addr,
  output logic                     query_hit,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    rd_mem   [DEPTH];
  logic [63:0]   data_mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [63:0]   rf_wdata_q, rf_wdata_d;

  logic          buf_nonempty;
  logic          forced;
  logic          grant_buf;
  logic          grant_pipe;
  logic          push;
  logic [4:0]    head_rd;
  logic [PW-1:0] scan_idx;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    buf_nonempty = (count_q != '0);
    forced       = (starve_q == SW'(STARVE_LIMIT)) && buf_nonempty;
    grant_buf    = forced || (!pipe_valid && buf_nonempty);
    grant_pipe   = pipe_valid && !forced;
    mdu_ready    = (count_q < CW'(DEPTH));
    push         = mdu_valid && mdu_ready;
    pipe_stall   = forced && pipe_valid;
    head_rd      = rd_mem[head_q];

    // Only occupied slots participate; x0 is never a real hazard.
    query_hit = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && (rd_mem[scan_idx] == query_addr) && (query_addr != 5'd0))
        query_hit = 1'b1;
    end
  end

  always_comb begin
    head_d  = grant_buf ? head_q + PW'(1) : head_q;
    tail_d  = push      ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    if (push && !grant_buf)
      count_d = count_q + CW'(1);
    else if (!push && grant_buf)
      count_d = count_q - CW'(1);

    // Saturates at the limit so the head keeps winning until it actually pops.
    starve_d = starve_q;
    if (grant_buf || !buf_nonempty)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + SW'(1);

    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_buf) begin
      rf_we_d    = (head_rd != 5'd0);
      rf_waddr_d = head_rd;
      rf_wdata_d = data_mem[head_q];
    end else if (grant_pipe) begin
      rf_we_d    = pipe_we && (pipe_rd != 5'd0);
      rf_waddr_d = pipe_rd;
      rf_wdata_d = pipe_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // NOTE: payload storage is not reset; count_q alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_q]   <= mdu_rd;
      data_mem[tail_q] <= mdu_data;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign count    = count_q;

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback stage and the long-latency multiply/divide unit (MDU). MDU results are held in a small FIFO and drained into idle writeback slots. A starvation counter can freeze the pipeline so buffered results always retire. Sits between the writeback stage and the register file, and exposes a pending-write query for the hazard unit.

## Interface
Parameters:
- DEPTH, 2: MDU result buffer entries; power of two, ≥2.
- STARVE_LIMIT, 4: cycles a buffered head may wait before the pipeline is forcibly stalled; ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- pipe_valid  in  1  writeback stage presents an entry.
- pipe_we  in  1  entry writes a register.
- pipe_rd  in  5  destination register.
- pipe_data  in  64  write data.
- pipe_stall  out  1  combinational; pipeline entry not accepted this cycle, and the pipeline must hold it.
- mdu_valid  in  1  MDU result available.
- mdu_rd  in  5  MDU destination register.
- mdu_data  in  64  MDU result.
- mdu_ready  out  1  combinational; buffer can accept.
- rf_we  out  1  registered register-file write enable.
- rf_waddr  out  5  registered write address.
- rf_wdata  out  64  registered write data.
- query_addr  in  5  register address from the hazard unit.
- query_hit  out  1  combinational; a buffered MDU write to query_addr is pending.
- count  out  $clog2(DEPTH)+1  current buffer occupancy.

## Operation
- Buffer: circular FIFO with head/tail pointers that wrap modulo DEPTH.
  - mdu_ready = (count < DEPTH). count is evaluated before this cycle's pop.
  - Push on mdu_valid && mdu_ready.
- Starvation counter `starve` (0..STARVE_LIMIT, saturating):
  - Cleared when the head pops or when count == 0.
  - Otherwise increments each cycle the head is not granted.
- Grant, one per cycle, in priority order:
  1. If starve == STARVE_LIMIT and count > 0: grant buffer head; pipe_stall = 1.
  2. Else if pipe_valid: grant pipeline; pipe_stall = 0.
  3. Else if count > 0: grant buffer head.
  4. Else: no grant.
- pipe_stall is 1 only in case 1. It is never asserted when pipe_valid = 0.
- Granted entry writes the register file the next cycle:
  - rf_we = granted && we && rd != 0. For the buffer, we is implicitly 1.
  - rf_waddr and rf_wdata take the granted entry's values.
- A granted entry with rd == 0 or pipe_we == 0 still consumes the slot and pops or acknowledges, with rf_we = 0.
- query_hit = OR over valid buffer entries of (rd == query_addr && rd != 0). The entry in the rf_* output register is excluded; the register file handles that bypass.
- count = number of valid entries. Push and pop in the same cycle leave count unchanged.

## Timing
- Reset (asynchronous): count = 0, pointers = 0, starve = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0. All buffered entries are discarded. Combinational outputs follow: mdu_ready = 1, pipe_stall = 0, query_hit = 0.
- Pipeline path latency: accepted in cycle N → rf_* valid in cycle N+1.
- MDU path: pushed in cycle N → earliest pop in N+1 → rf write in N+2. An entry pushed into an empty buffer is not granted in its push cycle.
- Full buffer with a simultaneous pop: mdu_ready stays 0 that cycle; the push is accepted the next cycle.
- Worst-case buffered wait under a continuous pipe_valid stream: STARVE_LIMIT cycles, then one forced grant. starve then clears; if entries remain, it restarts from 0.
- Consecutive forced grants occur only while starve re-reaches STARVE_LIMIT.
- No combinational path from mdu_valid to pipe_stall.

## Test plan
- Reset, then pipe_valid = 1, pipe_we = 1, pipe_rd = 5, pipe_data = 0xAA for one cycle → next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xAA; pipe_stall stays 0.
- Idle pipeline, MDU pushes rd = 7, data = 0x1234 in cycle 0 → count = 1 in cycle 1, query_addr = 7 gives query_hit = 1 in cycle 1; rf_we = 1 with rf_waddr = 7 in cycle 2; count = 0 in cycle 2.
- pipe_valid held at 1, one MDU push (STARVE_LIMIT = 4) → starve reaches 4 after 4 denied cycles; on the next cycle pipe_stall = 1 and the head is granted; the following cycle writes the MDU result; the pipeline entry is accepted afterwards.
- Fill the buffer (DEPTH = 2) while the pipeline is busy → mdu_ready = 0 with count = 2. A further mdu_valid is not accepted until a pop; after the pop, mdu_ready = 1.
- MDU result with rd = 0, and a pipeline entry with pipe_we = 0 → both consume slots, rf_we = 0, count decrements; query_addr = 0 never hits.
- Assert reset mid-operation with count = 2 and starve = 3 → immediately count = 0, rf_we = 0, mdu_ready = 1, pipe_stall = 0; no stale writes after reset deasserts.
